// File: rtl/dm_port_arbiter.sv
// Data-memory port arbiter: requester 0 has fixed priority, requester 1 is protected by an
// anti-starvation counter. One access per cycle, one response per accept, one cycle later.
module dm_port_arbiter #(
    parameter int unsigned XLEN      = 64,
    parameter int unsigned MEM_BYTES = 4096,
    parameter int unsigned MAX_WAIT  = 4
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic            r0_valid,
    input  logic            r0_write,
    input  logic [XLEN-1:0] r0_addr,
    input  logic [XLEN-1:0] r0_wdata,
    output logic            r0_ready,
    output logic            r0_rsp_valid,
    output logic [XLEN-1:0] r0_rsp_data,
    output logic            r0_rsp_error,

    input  logic            r1_valid,
    input  logic            r1_write,
    input  logic [XLEN-1:0] r1_addr,
    input  logic [XLEN-1:0] r1_wdata,
    output logic            r1_ready,
    output logic            r1_rsp_valid,
    output logic [XLEN-1:0] r1_rsp_data,
    output logic            r1_rsp_error,

    output logic            mem_read_enable,
    output logic            mem_write_enable,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_write_data,
    input  logic [XLEN-1:0] mem_read_data,

    output logic            starve_active
);

    localparam int unsigned WaitW = $clog2(MAX_WAIT + 1);
    localparam logic [WaitW-1:0] WaitMax = WaitW'(MAX_WAIT);
    localparam logic [XLEN-1:0] LastAddr = XLEN'(MEM_BYTES - XLEN / 8);

    typedef enum logic {StIdle, StResp} state_e;

    state_e           state_q;
    logic             owner_q;
    logic             is_read_q;
    logic             error_q;
    logic [WaitW-1:0] wait_cnt_q;

    logic            grant0;
    logic            grant1;
    logic            accept;
    logic            legal;
    logic            sel_write;
    logic [XLEN-1:0] sel_addr;
    logic [XLEN-1:0] sel_wdata;
    logic [XLEN-1:0] rsp_payload;
    logic            rsp_on;

    always_comb begin
        starve_active = (wait_cnt_q == WaitMax);
        grant1        = r1_valid && (starve_active || !r0_valid);
        grant0        = r0_valid && !grant1;
        // Handshake and memory strobes are gated by reset so nothing leaks while it is held.
        r0_ready      = grant0 && rst_n;
        r1_ready      = grant1 && rst_n;
        accept        = r0_ready || r1_ready;

        sel_write     = grant1 ? r1_write : r0_write;
        sel_addr      = grant1 ? r1_addr  : r0_addr;
        sel_wdata     = grant1 ? r1_wdata : r0_wdata;
        legal         = (sel_addr <= LastAddr);

        mem_addr         = sel_addr;
        mem_write_data   = sel_wdata;
        mem_read_enable  = accept && legal && !sel_write;
        mem_write_enable = accept && legal && sel_write;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            owner_q    <= 1'b0;
            is_read_q  <= 1'b0;
            error_q    <= 1'b0;
            wait_cnt_q <= '0;
        end else begin
            unique case (state_q)
                StIdle:  state_q <= accept ? StResp : StIdle;
                StResp:  state_q <= accept ? StResp : StIdle;
                default: state_q <= StIdle;
            endcase
            if (accept) begin
                owner_q   <= grant1;
                is_read_q <= !sel_write;
                error_q   <= !legal;
            end
            if (r1_valid && !grant1) begin
                if (!starve_active) begin
                    wait_cnt_q <= wait_cnt_q + 1'b1;
                end
            end else begin
                wait_cnt_q <= '0;
            end
        end
    end

    always_comb begin
        rsp_on       = (state_q == StResp);
        // Load data is forwarded straight from the synchronous memory output.
        rsp_payload  = (is_read_q && !error_q) ? mem_read_data : '0;
        r0_rsp_valid = rsp_on && !owner_q;
        r1_rsp_valid = rsp_on && owner_q;
        r0_rsp_data  = r0_rsp_valid ? rsp_payload : '0;
        r1_rsp_data  = r1_rsp_valid ? rsp_payload : '0;
        r0_rsp_error = r0_rsp_valid && error_q;
        r1_rsp_error = r1_rsp_valid && error_q;
    end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed bench for dm_port_arbiter: stimulus pushes expected responses, a monitor pops them.
`timescale 1ns/1ps
module tb_dm_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        r0_valid, r0_write, r1_valid, r1_write;
    logic [63:0] r0_addr, r0_wdata, r1_addr, r1_wdata;
    logic        r0_ready, r1_ready;
    logic        r0_rsp_valid, r1_rsp_valid, r0_rsp_error, r1_rsp_error;
    logic [63:0] r0_rsp_data, r1_rsp_data;
    logic        mem_read_enable, mem_write_enable, starve_active;
    logic [63:0] mem_addr, mem_write_data, mem_read_data;

    logic [63:0] mem [512];
    logic [64:0] q0 [$];
    logic [64:0] q1 [$];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dm_port_arbiter dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .r0_valid         (r0_valid),
        .r0_write         (r0_write),
        .r0_addr          (r0_addr),
        .r0_wdata         (r0_wdata),
        .r0_ready         (r0_ready),
        .r0_rsp_valid     (r0_rsp_valid),
        .r0_rsp_data      (r0_rsp_data),
        .r0_rsp_error     (r0_rsp_error),
        .r1_valid         (r1_valid),
        .r1_write         (r1_write),
        .r1_addr          (r1_addr),
        .r1_wdata         (r1_wdata),
        .r1_ready         (r1_ready),
        .r1_rsp_valid     (r1_rsp_valid),
        .r1_rsp_data      (r1_rsp_data),
        .r1_rsp_error     (r1_rsp_error),
        .mem_read_enable  (mem_read_enable),
        .mem_write_enable (mem_write_enable),
        .mem_addr         (mem_addr),
        .mem_write_data   (mem_write_data),
        .mem_read_data    (mem_read_data),
        .starve_active    (starve_active)
    );

    // Synchronous data memory model.
    always @(posedge clk) begin
        if (mem_write_enable) mem[mem_addr[11:3]] <= mem_write_data;
        if (mem_read_enable)  mem_read_data <= mem[mem_addr[11:3]];
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    // Monitor: responses are checked 3ns after each rising edge.
    always @(posedge clk) begin
        logic [64:0] e;
        #3;
        if (r0_rsp_valid) begin
            if (q0.size() == 0) chk("r0_unexpected_rsp", 64'(r0_rsp_valid), 64'd0);
            else begin
                e = q0.pop_front();
                chk("r0_rsp_data", r0_rsp_data, e[63:0]);
                chk("r0_rsp_error", 64'(r0_rsp_error), 64'(e[64]));
            end
        end else begin
            if (q0.size() != 0) begin
                chk("r0_missing_rsp", 64'(r0_rsp_valid), 64'd1);
                void'(q0.pop_front());
            end
            chk("r0_quiet_data", r0_rsp_data, 64'd0);
            chk("r0_quiet_error", 64'(r0_rsp_error), 64'd0);
        end
        if (r1_rsp_valid) begin
            if (q1.size() == 0) chk("r1_unexpected_rsp", 64'(r1_rsp_valid), 64'd0);
            else begin
                e = q1.pop_front();
                chk("r1_rsp_data", r1_rsp_data, e[63:0]);
                chk("r1_rsp_error", 64'(r1_rsp_error), 64'(e[64]));
            end
        end else begin
            if (q1.size() != 0) begin
                chk("r1_missing_rsp", 64'(r1_rsp_valid), 64'd1);
                void'(q1.pop_front());
            end
            chk("r1_quiet_data", r1_rsp_data, 64'd0);
            chk("r1_quiet_error", 64'(r1_rsp_error), 64'd0);
        end
    end

    task automatic step(input string nm,
                        input logic v0, input logic w0, input logic [63:0] a0, input logic [63:0] d0,
                        input logic v1, input logic w1, input logic [63:0] a1, input logic [63:0] d1,
                        input logic e_rdy0, input logic e_rdy1, input logic e_re, input logic e_we,
                        input logic e_starve, input logic e_err, input logic [63:0] e_data);
        @(negedge clk);
        r0_valid = v0; r0_write = w0; r0_addr = a0; r0_wdata = d0;
        r1_valid = v1; r1_write = w1; r1_addr = a1; r1_wdata = d1;
        #1;
        chk({nm, ".r0_ready"}, 64'(r0_ready), 64'(e_rdy0));
        chk({nm, ".r1_ready"}, 64'(r1_ready), 64'(e_rdy1));
        chk({nm, ".mem_re"}, 64'(mem_read_enable), 64'(e_re));
        chk({nm, ".mem_we"}, 64'(mem_write_enable), 64'(e_we));
        chk({nm, ".starve"}, 64'(starve_active), 64'(e_starve));
        if (e_re || e_we) chk({nm, ".mem_addr"}, mem_addr, e_rdy1 ? a1 : a0);
        if (e_we) chk({nm, ".mem_wdata"}, mem_write_data, e_rdy1 ? d1 : d0);
        if (e_rdy0) q0.push_back({e_err, e_data});
        if (e_rdy1) q1.push_back({e_err, e_data});
    endtask

    task automatic idle(input string nm);
        step(nm, 0, 0, 64'h0, 64'h0, 0, 0, 64'h0, 64'h0, 0, 0, 0, 0, 0, 0, 64'h0);
    endtask

    localparam logic [63:0] DB = 64'hDEADBEEF_01234567;
    localparam logic [63:0] V1 = 64'h11112222_33334444;
    localparam logic [63:0] VT = 64'hCAFEF00D_0BADC0DE;

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 64'h0;
        mem[8'h40 >> 3]  = DB;
        mem[12'h100 >> 3] = V1;
        mem[511]          = VT;
        mem_read_data     = 64'h0;
        rst_n = 1'b0;
        r0_valid = 1; r0_write = 0; r0_addr = 64'h40; r0_wdata = 0;
        r1_valid = 1; r1_write = 0; r1_addr = 64'h100; r1_wdata = 0;
        #3;
        chk("rst.r0_ready", 64'(r0_ready), 64'd0);
        chk("rst.r1_ready", 64'(r1_ready), 64'd0);
        chk("rst.mem_re", 64'(mem_read_enable), 64'd0);
        chk("rst.mem_we", 64'(mem_write_enable), 64'd0);
        chk("rst.starve", 64'(starve_active), 64'd0);
        chk("rst.r0_rsp_valid", 64'(r0_rsp_valid), 64'd0);
        chk("rst.r1_rsp_valid", 64'(r1_rsp_valid), 64'd0);
        r0_valid = 0; r1_valid = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Plain load, then store/load back-to-back on r0.
        step("load", 1, 0, 64'h40, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, DB);
        step("st80", 1, 1, 64'h80, 64'h55, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 64'h0);
        step("ld80", 1, 0, 64'h80, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 64'h55);
        // r1 store, r0 reads it back; then address boundaries.
        step("r1st", 0, 0, 0, 0, 1, 1, 64'h200, 64'hA5, 0, 1, 0, 1, 0, 0, 64'h0);
        step("ld200", 1, 0, 64'h200, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 64'hA5);
        step("ldlast", 1, 0, 64'd4088, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, VT);
        step("st_oob", 1, 1, 64'd4089, 64'h77, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 64'h0);
        step("r1_err", 0, 0, 0, 0, 1, 0, 64'd4096, 0, 0, 1, 0, 0, 0, 1, 64'h0);
        step("hi_bit", 0, 0, 0, 0, 1, 0, 64'h8000_0000_0000_0040, 0, 0, 1, 0, 0, 0, 1, 64'h0);
        idle("gap");

        // Contention: r0 wins four times, then r1 takes one slot.
        step("ct1", 1, 0, 64'h40, 0, 1, 0, 64'h100, 0, 1, 0, 1, 0, 0, 0, DB);
        step("ct2", 1, 0, 64'h40, 0, 1, 0, 64'h100, 0, 1, 0, 1, 0, 0, 0, DB);
        step("ct3", 1, 0, 64'h40, 0, 1, 0, 64'h100, 0, 1, 0, 1, 0, 0, 0, DB);
        step("ct4", 1, 0, 64'h40, 0, 1, 0, 64'h100, 0, 1, 0, 1, 0, 0, 0, DB);
        step("ct5", 1, 0, 64'h40, 0, 1, 0, 64'h100, 0, 0, 1, 1, 0, 1, 0, V1);
        step("ct6", 1, 0, 64'h40, 0, 1, 0, 64'h100, 0, 1, 0, 1, 0, 0, 0, DB);
        step("ct7", 0, 0, 0, 0, 1, 0, 64'h100, 0, 0, 1, 1, 0, 0, 0, V1);
        idle("gap2");

        // Reset while a load response is pending: it must be dropped.
        @(negedge clk);
        r0_valid = 1; r0_write = 0; r0_addr = 64'h40;
        #1;
        chk("rstp.accept", 64'(r0_ready), 64'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rstp.r0_ready", 64'(r0_ready), 64'd0);
        chk("rstp.mem_re", 64'(mem_read_enable), 64'd0);
        chk("rstp.r0_rsp_valid", 64'(r0_rsp_valid), 64'd0);
        chk("rstp.r0_rsp_data", r0_rsp_data, 64'd0);
        chk("rstp.starve", 64'(starve_active), 64'd0);
        @(negedge clk);
        r0_valid = 0;
        @(negedge clk);
        rst_n = 1'b1;
        step("post_rst", 1, 0, 64'h40, 0, 1, 0, 64'h100, 0, 1, 0, 1, 0, 0, 0, DB);

        for (int i = 0; i < 10; i++) idle("idle");
        @(negedge clk);
        chk("drain.q0", 64'(q0.size()), 64'd0);
        chk("drain.q1", 64'(q1.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dm_port_arbiter.md
Name: dm_port_arbiter

Overview:
- Shares the single data-memory port between two requesters.
- Requester 0 is the pipeline memory-access stage, with priority. Requester 1 is a secondary master, e.g. program loader or debug, protected by an anti-starvation counter.
- Issues at most one read or write per cycle to the data memory. Returns exactly one response per accepted request, one cycle later, routed to its owner.
- Range-checks addresses; out-of-range requests get an error response and never reach the memory.

Parameters:
- XLEN, 64, data/address width.
- MEM_BYTES, 4096, data memory size in bytes; legal address range is 0 .. MEM_BYTES-XLEN/8.
- MAX_WAIT, 4, consecutive cycles requester 1 may be refused before it wins priority once.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- r0_valid / r1_valid  in  1  request valid.
- r0_write / r1_write  in  1  1 = store, 0 = load.
- r0_addr / r1_addr  in  XLEN  byte address.
- r0_wdata / r1_wdata  in  XLEN  store data.
- r0_ready / r1_ready  out  1  request accepted this cycle.
- r0_rsp_valid / r1_rsp_valid  out  1  response pulse.
- r0_rsp_data / r1_rsp_data  out  XLEN  load data; 0 for stores and errors.
- r0_rsp_error / r1_rsp_error  out  1  address out of range.
- mem_read_enable  out  1  to data memory.
- mem_write_enable  out  1  to data memory.
- mem_addr  out  XLEN  shared read/write address.
- mem_write_data  out  XLEN  store data.
- mem_read_data  in  XLEN  synchronous read data, valid the cycle after mem_read_enable.
- starve_active  out  1  requester 1 currently holds priority, for debug.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All rsp_valid and rsp_error are 0, rsp_data is 0, wait_cnt is 0, state is IDLE.
  - ready outputs, mem_read_enable and mem_write_enable are forced to 0 while reset is asserted.
- Handshake:
  - A request is accepted when valid && ready in the same cycle.
  - The requester holds valid and payload stable until accepted.
  - ready is combinational from the grant; at most one ready is high per cycle.
- Grant:
  - Requester 0 wins if r0_valid, unless wait_cnt == MAX_WAIT, in which case requester 1 wins if r1_valid.
  - Otherwise requester 1 wins if only r1_valid is high.
  - No valid: no grant and both memory enables stay 0.
- wait_cnt:
  - Increments, saturating at MAX_WAIT, each cycle r1_valid is high and requester 1 is not granted.
  - Clears when requester 1 is granted or r1_valid is low.
  - starve_active = (wait_cnt == MAX_WAIT).
- Issue (cycle N, granted request with legal address):
  - mem_addr and mem_write_data come from the winner.
  - mem_read_enable = !write; mem_write_enable = write.
  - The two enables are never both high.
- Illegal address (addr > MEM_BYTES-XLEN/8):
  - The request is still accepted.
  - Both memory enables stay 0.
- Response, cycle N+1:
  - State machine: IDLE -> RESP on any accept; RESP -> RESP on an accept in the same cycle; RESP -> IDLE otherwise.
  - Registered fields: owner, is_read, error.
  - In RESP, owner's rsp_valid = 1 for exactly one cycle.
  - Load: rsp_data = mem_read_data, passed through combinationally.
  - Store: rsp_data = 0.
  - Error: rsp_error = 1 and rsp_data = 0.
  - The non-owner sees rsp_valid = 0 and rsp_data = 0.
- Throughput and latency:
  - A new request may be accepted in the same cycle a response is delivered, giving 1 access per cycle.
  - Load latency is 1 cycle accept-to-response.
- Simultaneous requests: the loser's ready stays 0 and its request is presented again next cycle.
- Reset during a pending response: the response is dropped, and no rsp_valid appears after reset release until a new accept.
- Unused address bits above the range are not masked; they only trigger the error.

Test Plan:
- Load: preload mem[0x40] = 0xDEADBEEF_01234567; r0 load 0x40 -> r0_ready same cycle, mem_read_enable = 1, next cycle r0_rsp_valid = 1 and r0_rsp_data = 0xDEADBEEF_01234567, r1 outputs 0.
- Back-to-back: r0 store 0x80 = 0x55, then load 0x80 the next cycle -> two single-cycle accepts, store ack (data 0), then load response data 0x55.
- Contention: r0 and r1 both valid continuously with MAX_WAIT = 4 -> r0 granted 4 cycles, starve_active = 1, r1 granted on the 5th, wait_cnt back to 0, r0 resumes.
- Error: r1 load at MEM_BYTES -> r1_ready = 1, both memory enables 0, next cycle r1_rsp_error = 1 and r1_rsp_data = 0.
- Reset: assert rst_n low in the cycle after a load accept -> no rsp_valid during or after reset, all outputs 0, wait_cnt 0.
- Idle: neither valid for 10 cycles -> memory enables 0, no responses, starve_active = 0.
